// File: rtl/sys1_rom_loader_if.sv
// hps_io ioctl download port and the game core ROM write / control port.
// The master side is the download source; the slave side is the loader.
interface sys1_rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [16:0] rom_ad;
  logic [7:0]  rom_dt;
  logic [4:0]  rom_we;
  logic        core_reset;
  logic        load_done;
  logic        load_err;
  logic [7:0]  tno;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    input  rom_ad, rom_dt, rom_we, core_reset, load_done, load_err, tno
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    output rom_ad, rom_dt, rom_we, core_reset, load_done, load_err, tno
  );
endinterface

// File: rtl/sys1_rom_loader.sv
// Splits the flat System 1 ROM image into per-region write strobes, one cycle after ioctl_wr,
// and holds the core in reset through the download plus a settle window; no backpressure.
module sys1_rom_loader #(
  parameter int CPU_SIZE    = 'h0C000,
  parameter int SND_SIZE    = 'h02000,
  parameter int BG_SIZE     = 'h0C000,
  parameter int SP_SIZE     = 'h10000,
  parameter int PROM_SIZE   = 'h00300,
  parameter int HOLD_CYCLES = 16
) (
  input logic              clk_sys,
  input logic              reset_n,
  sys1_rom_loader_if.slave bus
);

  localparam logic [24:0] B_SND   = 25'(CPU_SIZE);
  localparam logic [24:0] B_BG    = 25'(CPU_SIZE + SND_SIZE);
  localparam logic [24:0] B_SP    = 25'(CPU_SIZE + SND_SIZE + BG_SIZE);
  localparam logic [24:0] B_PROM  = 25'(CPU_SIZE + SND_SIZE + BG_SIZE + SP_SIZE);
  localparam logic [24:0] TOTAL   = 25'(CPU_SIZE + SND_SIZE + BG_SIZE + SP_SIZE + PROM_SIZE);
  localparam int          HCW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t      state;
  logic [24:0] byte_cnt;
  logic [HCW-1:0] hold_cnt;

  logic [4:0]  dec_we;
  logic [24:0] dec_base;
  logic        in_range;
  logic        img_wr;
  logic        dl_start;
  logic [24:0] cnt_next;

  assign in_range = bus.ioctl_addr < TOTAL;
  assign img_wr   = bus.ioctl_wr && (bus.ioctl_index == 8'd0);
  assign dl_start = bus.ioctl_download && (bus.ioctl_index == 8'd0);
  assign cnt_next = (img_wr && in_range && (byte_cnt != '1)) ? byte_cnt + 25'd1 : byte_cnt;

  always_comb begin
    dec_we   = '0;
    dec_base = '0;
    if (bus.ioctl_addr < B_SND) begin
      dec_we = 5'b00001;
    end else if (bus.ioctl_addr < B_BG) begin
      dec_we   = 5'b00010;
      dec_base = B_SND;
    end else if (bus.ioctl_addr < B_SP) begin
      dec_we   = 5'b00100;
      dec_base = B_BG;
    end else if (bus.ioctl_addr < B_PROM) begin
      dec_we   = 5'b01000;
      dec_base = B_SP;
    end else if (in_range) begin
      dec_we   = 5'b10000;
      dec_base = B_PROM;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      hold_cnt       <= '0;
      bus.rom_ad     <= '0;
      bus.rom_dt     <= '0;
      bus.rom_we     <= '0;
      bus.core_reset <= 1'b1;
      bus.load_done  <= 1'b0;
      bus.load_err   <= 1'b0;
      bus.tno        <= '0;
    end else begin
      bus.rom_we <= '0;

      // The variant byte may arrive at any time and never disturbs the image sequencing.
      if (bus.ioctl_wr && (bus.ioctl_index == 8'd1) && (bus.ioctl_addr == '0))
        bus.tno <= bus.ioctl_dout;

      case (state)
        IDLE: begin
          bus.core_reset <= 1'b1;
          if (dl_start) begin
            state         <= LOAD;
            byte_cnt      <= '0;
            bus.load_err  <= 1'b0;
            bus.load_done <= 1'b0;
          end
        end

        LOAD: begin
          if (img_wr) begin
            if (in_range) begin
              bus.rom_we <= dec_we;
              bus.rom_ad <= 17'(bus.ioctl_addr - dec_base);
              bus.rom_dt <= bus.ioctl_dout;
            end else begin
              bus.load_err <= 1'b1;
            end
          end
          byte_cnt <= cnt_next;
          // A write in the final download cycle is already folded into cnt_next.
          if (!bus.ioctl_download) begin
            state    <= HOLD;
            hold_cnt <= HCW'(HOLD_CYCLES - 1);
            if (cnt_next != TOTAL)
              bus.load_err <= 1'b1;
          end
        end

        HOLD: begin
          if (hold_cnt == '0) begin
            state          <= RUN;
            bus.core_reset <= 1'b0;
            bus.load_done  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        RUN: begin
          if (dl_start) begin
            state          <= LOAD;
            byte_cnt       <= '0;
            bus.core_reset <= 1'b1;
            bus.load_done  <= 1'b0;
            bus.load_err   <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys1_rom_loader.sv
// Randomised download stimulus against a region-table reference model with a queued scoreboard.
module tb_sys1_rom_loader;

  localparam int SZ_CPU = 'hC0, SZ_SND = 'h20, SZ_BG = 'hC0, SZ_SP = 'h100, SZ_PROM = 'h30;
  localparam int HOLD   = 16;

  int sz [5] = '{SZ_CPU, SZ_SND, SZ_BG, SZ_SP, SZ_PROM};
  int total;

  typedef struct packed {
    logic [4:0]  we;
    logic [16:0] ad;
    logic [7:0]  dt;
  } exp_t;

  exp_t sbq[$];

  logic clk;
  logic reset_n;
  sys1_rom_loader_if bus();

  sys1_rom_loader #(
    .CPU_SIZE(SZ_CPU), .SND_SIZE(SZ_SND), .BG_SIZE(SZ_BG),
    .SP_SIZE(SZ_SP), .PROM_SIZE(SZ_PROM), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int model_cnt;
  bit model_err;
  bit in_load;
  int reg_cnt [5];
  logic [16:0] last_ad;
  logic [7:0]  last_dt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the region table, each region starting where the previous one ends.
  function automatic void model_wr(input int addr, input logic [7:0] d);
    int  base = 0;
    bit  found = 0;
    exp_t e;
    if (addr >= total) begin
      model_err = 1;
    end else begin
      for (int r = 0; r < 5; r++) begin
        if (!found && addr < base + sz[r]) begin
          e.we = 5'(1 << r);
          e.ad = 17'(addr - base);
          e.dt = d;
          sbq.push_back(e);
          model_cnt++;
          found = 1;
        end
        base += sz[r];
      end
    end
  endfunction

  task automatic wr_byte(input logic [7:0] idx, input int addr, input logic [7:0] d, input bit drop_dl);
    bus.ioctl_index = idx;
    bus.ioctl_addr  = 25'(addr);
    bus.ioctl_dout  = d;
    bus.ioctl_wr    = 1'b1;
    if (drop_dl) bus.ioctl_download = 1'b0;
    if (idx == 8'd0 && in_load) model_wr(addr, d);
    @(negedge clk);
    bus.ioctl_wr    = 1'b0;
    bus.ioctl_index = 8'd0;
  endtask

  task automatic start_dl();
    bus.ioctl_index    = 8'd0;
    bus.ioctl_download = 1'b1;
    @(negedge clk);
    chk("start_core_reset", 32'(bus.core_reset), 32'd1);
    chk("start_load_done", 32'(bus.load_done), 32'd0);
    model_cnt = 0;
    model_err = 0;
    in_load   = 1;
    for (int r = 0; r < 5; r++) reg_cnt[r] = 0;
  endtask

  task automatic send_image(input int n, input bit drop_last);
    for (int a = 0; a < n; a++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      wr_byte(8'd0, a, 8'($urandom), drop_last && (a == n - 1));
    end
  endtask

  task automatic end_dl(input bit dropped);
    if (!dropped) begin
      bus.ioctl_download = 1'b0;
      @(negedge clk);
    end
    in_load = 0;
    if (model_cnt != total) model_err = 1;
    for (int i = 1; i <= HOLD; i++) begin
      if (i == 1 || i == HOLD) begin
        chk("hold_core_reset", 32'(bus.core_reset), 32'd1);
        chk("hold_load_done", 32'(bus.load_done), 32'd0);
      end
      @(negedge clk);
    end
    chk("run_core_reset", 32'(bus.core_reset), 32'd0);
    chk("run_load_done", 32'(bus.load_done), 32'd1);
    chk("run_load_err", 32'(bus.load_err), 32'(model_err));
  endtask

  // Monitor: observes just after each rising edge, decoupled from the stimulus.
  initial begin
    exp_t e;
    last_ad = '0;
    last_dt = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        last_ad = '0;
        last_dt = '0;
      end else if (bus.rom_we != '0) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: rom_we=%b rom_ad=%h, nothing expected", bus.rom_we, bus.rom_ad);
        end else begin
          e = sbq.pop_front();
          chk("sb_rom_we", 32'(bus.rom_we), 32'(e.we));
          chk("sb_rom_ad", 32'(bus.rom_ad), 32'(e.ad));
          chk("sb_rom_dt", 32'(bus.rom_dt), 32'(e.dt));
        end
        for (int r = 0; r < 5; r++) reg_cnt[r] += int'(bus.rom_we[r]);
        last_ad = bus.rom_ad;
        last_dt = bus.rom_dt;
      end else begin
        chk("hold_rom_ad", 32'(bus.rom_ad), 32'(last_ad));
        chk("hold_rom_dt", 32'(bus.rom_dt), 32'(last_dt));
      end
    end
  end

  initial begin
    int bnd [$];
    total = 0;
    for (int r = 0; r < 5; r++) total += sz[r];
    in_load = 0;
    model_cnt = 0;
    model_err = 0;
    reset_n = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) @(negedge clk);

    chk("rst_rom_we", 32'(bus.rom_we), 32'd0);
    chk("rst_rom_ad", 32'(bus.rom_ad), 32'd0);
    chk("rst_rom_dt", 32'(bus.rom_dt), 32'd0);
    chk("rst_core_reset", 32'(bus.core_reset), 32'd1);
    chk("rst_load_done", 32'(bus.load_done), 32'd0);
    chk("rst_load_err", 32'(bus.load_err), 32'd0);
    chk("rst_tno", 32'(bus.tno), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Full image; last write coincides with download falling; variant byte mid-load.
    start_dl();
    for (int a = 0; a < total; a++) begin
      if (a == 100) wr_byte(8'd1, 0, 8'h5A, 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      wr_byte(8'd0, a, 8'($urandom), a == total - 1);
    end
    end_dl(1);
    chk("full_tno", 32'(bus.tno), 32'h5A);
    for (int r = 0; r < 5; r++) chk("full_region_count", 32'(reg_cnt[r]), 32'(sz[r]));

    // Region edges, written back to back.
    start_dl();
    bnd = '{SZ_CPU - 1, SZ_CPU, SZ_CPU + SZ_SND - 1, SZ_CPU + SZ_SND,
            SZ_CPU + SZ_SND + SZ_BG - 1, SZ_CPU + SZ_SND + SZ_BG,
            total - SZ_PROM - 1, total - SZ_PROM, total - 1};
    foreach (bnd[i]) wr_byte(8'd0, bnd[i], 8'($urandom), 0);
    end_dl(0);

    // Short image followed by an out-of-range write.
    start_dl();
    send_image(total - 1, 0);
    wr_byte(8'd0, total, 8'hA5, 0);
    end_dl(0);
    chk("short_load_err", 32'(bus.load_err), 32'd1);

    // Reset mid-load, with a write in flight on the reset cycle.
    start_dl();
    send_image('h50, 0);
    in_load = 0;
    bus.ioctl_addr     = 25'h50;
    bus.ioctl_dout     = 8'h11;
    bus.ioctl_wr       = 1'b1;
    bus.ioctl_download = 1'b0;
    reset_n            = 1'b0;
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
    chk("midrst_rom_we", 32'(bus.rom_we), 32'd0);
    chk("midrst_core_reset", 32'(bus.core_reset), 32'd1);
    chk("midrst_load_done", 32'(bus.load_done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    wr_byte(8'd0, 5, 8'h33, 0);
    repeat (3) @(negedge clk);
    chk("idle_core_reset", 32'(bus.core_reset), 32'd1);
    start_dl();
    send_image(total, 0);
    end_dl(0);

    // Variant byte in RUN; other addresses and indices leave it alone.
    wr_byte(8'd1, 0, 8'h03, 0);
    chk("run_tno", 32'(bus.tno), 32'h03);
    chk("run_tno_core_reset", 32'(bus.core_reset), 32'd0);
    wr_byte(8'd1, 4, 8'hEE, 0);
    wr_byte(8'd2, 0, 8'h77, 0);
    chk("run_tno_kept", 32'(bus.tno), 32'h03);
    chk("run_idx2_load_done", 32'(bus.load_done), 32'd1);

    // Reload from RUN.
    start_dl();
    send_image(total, 0);
    end_dl(0);

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
